// File: rtl/edge_pulse_gen.sv
// Multi-channel input conditioner: per channel a synchroniser, a counter
// debouncer, edge-mode event detection, and one-cycle, stretched and sticky
// event outputs. All channels share clock, reset and the edge-mode select.
module edge_pulse_gen #(
    parameter int unsigned CH              = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_LEN       = 8,
    parameter logic        RST_LEVEL       = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CH-1:0] edge_sig,
    input  logic [1:0]    mode,
    input  logic [CH-1:0] clr,
    output logic [CH-1:0] pulse_o,
    output logic [CH-1:0] stretch_o,
    output logic [CH-1:0] sticky_o,
    output logic [CH-1:0] level_o
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PW = $clog2(PULSE_LEN + 1);

    logic [CH-1:0][SYNC_STAGES-1:0] sync_q;
    logic [CH-1:0][DW-1:0]          db_cnt;
    logic [CH-1:0][PW-1:0]          st_cnt;
    logic [CH-1:0]                  event_q;

    logic [CH-1:0] synced_c;
    logic [CH-1:0] differ_c;
    logic [CH-1:0] flip_c;
    logic [CH-1:0] event_c;

    // Synchroniser chains: raw input enters stage 0, last stage is the synced level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {(CH * SYNC_STAGES){RST_LEVEL}};
        end else begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], edge_sig[i]};
            end
        end
    end

    // Flip decision and edge qualification; the flip fires on the cycle the count would reach DEBOUNCE_CYCLES
    always_comb begin
        synced_c = '0;
        differ_c = '0;
        flip_c   = '0;
        event_c  = '0;
        for (int i = 0; i < CH; i++) begin
            synced_c[i] = sync_q[i][SYNC_STAGES-1];
            differ_c[i] = synced_c[i] != level_o[i];
            flip_c[i]   = differ_c[i] && (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1));
            event_c[i]  = flip_c[i] & ((mode[0] & ~level_o[i]) | (mode[1] & level_o[i]));
        end
    end

    // Debouncer: any cycle of agreement restarts the count, an accepted flip clears it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt  <= '0;
            level_o <= {CH{RST_LEVEL}};
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (!differ_c[i]) begin
                    db_cnt[i] <= '0;
                end else if (flip_c[i]) begin
                    db_cnt[i]  <= '0;
                    level_o[i] <= ~level_o[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Capture qualified events at the flip edge so mode is sampled only there
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_q <= '0;
        end else begin
            event_q <= event_c;
        end
    end

    // One-cycle pulse and sticky flag; a same-cycle event beats clr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_o  <= '0;
            sticky_o <= '0;
        end else begin
            pulse_o  <= event_q;
            sticky_o <= event_q | (sticky_o & ~clr);
        end
    end

    // Stretched pulse: an event reloads the remaining count, so retriggers extend without a gap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_cnt    <= '0;
            stretch_o <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (event_q[i]) begin
                    st_cnt[i]    <= PW'(PULSE_LEN - 1);
                    stretch_o[i] <= 1'b1;
                end else if (st_cnt[i] != '0) begin
                    st_cnt[i] <= st_cnt[i] - PW'(1);
                end else begin
                    stretch_o[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Self-checking bench for edge_pulse_gen with a window-based reference model.
module tb_edge_pulse_gen;

    localparam int CH = 4;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int L  = 8;

    logic          clk;
    logic          reset_n;
    logic [CH-1:0] edge_sig;
    logic [1:0]    mode;
    logic [CH-1:0] clr;
    logic [CH-1:0] pulse_o;
    logic [CH-1:0] stretch_o;
    logic [CH-1:0] sticky_o;
    logic [CH-1:0] level_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: histories of raw samples, synced levels and pulses
    logic [CH-1:0] m_raw[$];
    logic [CH-1:0] m_syn[$];
    logic [CH-1:0] m_pul[$];
    logic [CH-1:0] m_level;
    logic [CH-1:0] m_ev;
    logic [CH-1:0] m_sticky;
    logic [CH-1:0] exp_pulse;
    logic [CH-1:0] exp_stretch;
    logic [CH-1:0] exp_sticky;
    logic [CH-1:0] exp_level;

    edge_pulse_gen #(
        .CH(CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .PULSE_LEN(L), .RST_LEVEL(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .edge_sig(edge_sig), .mode(mode), .clr(clr),
        .pulse_o(pulse_o), .stretch_o(stretch_o), .sticky_o(sticky_o), .level_o(level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_raw.delete();
        m_syn.delete();
        m_pul.delete();
        m_level     = {CH{1'b1}};
        m_ev        = '0;
        m_sticky    = '0;
        exp_pulse   = '0;
        exp_stretch = '0;
        exp_sticky  = '0;
        exp_level   = {CH{1'b1}};
    endtask

    // Advance one clock; the level flips once the last D synced samples all disagree with it
    task automatic step();
        logic [CH-1:0] flip;
        logic [CH-1:0] syn;
        logic [CH-1:0] pul;
        bit ok;
        @(posedge clk);
        flip = '0;
        for (int ch = 0; ch < CH; ch++) begin
            ok = (m_syn.size() >= D);
            for (int j = 0; j < D; j++) begin
                if (ok && m_syn[m_syn.size() - 1 - j][ch] == m_level[ch]) ok = 1'b0;
            end
            flip[ch] = ok;
        end
        pul     = m_ev;
        m_ev    = flip & (({CH{mode[0]}} & ~m_level) | ({CH{mode[1]}} & m_level));
        m_level = m_level ^ flip;
        m_raw.push_back(edge_sig);
        syn = (m_raw.size() >= S) ? m_raw[m_raw.size() - S] : {CH{1'b1}};
        m_syn.push_back(syn);
        m_pul.push_back(pul);
        exp_stretch = '0;
        for (int j = 0; j < L; j++) begin
            if (j < m_pul.size()) exp_stretch = exp_stretch | m_pul[m_pul.size() - 1 - j];
        end
        m_sticky   = pul | (m_sticky & ~clr);
        exp_pulse  = pul;
        exp_sticky = m_sticky;
        exp_level  = m_level;
        while (m_raw.size() > 32) void'(m_raw.pop_front());
        while (m_syn.size() > 32) void'(m_syn.pop_front());
        while (m_pul.size() > 32) void'(m_pul.pop_front());
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        edge_sig = 4'hF;
        mode     = 2'b11;
        clr      = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pulse_o, stretch_o, sticky_o, level_o} !== {4'h0, 4'h0, 4'h0, 4'hF}) begin
            errors++;
            $display("FAIL reset_state got p=%h s=%h k=%h l=%h exp p=0 s=0 k=0 l=f",
                     pulse_o, stretch_o, sticky_o, level_o);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            checks++;
            if ({pulse_o, stretch_o, sticky_o, level_o} !== {4'h0, 4'h0, 4'h0, 4'hF}) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got p=%h s=%h k=%h l=%h exp p=0 s=0 k=0 l=f",
                         c, pulse_o, stretch_o, sticky_o, level_o);
            end
        end
    endtask

    task automatic test_falling();
        int first = -1;
        int scount = 0;
        mode = 2'b10;
        edge_sig = 4'hE;
        for (int c = 0; c < 20; c++) begin
            step();
            if (pulse_o[0] && first < 0) first = c;
            if (stretch_o[0]) scount++;
            checks++;
            if ({pulse_o, stretch_o, sticky_o, level_o} !== {exp_pulse, exp_stretch, exp_sticky, exp_level}) begin
                errors++;
                $display("FAIL falling_model cyc=%0d got p=%h s=%h k=%h l=%h exp p=%h s=%h k=%h l=%h", c,
                         pulse_o, stretch_o, sticky_o, level_o, exp_pulse, exp_stretch, exp_sticky, exp_level);
            end
            if (c == 6) begin
                checks++;
                if (pulse_o !== 4'h1) begin
                    errors++;
                    $display("FAIL falling_pulse_time got %h exp 1", pulse_o);
                end
            end
        end
        checks++;
        if (first != 6 || scount != 8 || sticky_o !== 4'h1 || level_o !== 4'hE) begin
            errors++;
            $display("FAIL falling_summary got first=%0d stretch=%0d k=%h l=%h exp first=6 stretch=8 k=1 l=e",
                     first, scount, sticky_o, level_o);
        end
    endtask

    task automatic test_glitch();
        int pcount;
        int lowlen;
        bit level_dropped;
        for (int t = 0; t < 2; t++) begin
            pcount = 0;
            level_dropped = 1'b0;
            lowlen = (t == 0) ? 3 : 4;
            edge_sig[1] = 1'b0;
            for (int c = 0; c < lowlen + 15; c++) begin
                if (c == lowlen) edge_sig[1] = 1'b1;
                step();
                if (pulse_o[1]) pcount++;
                if (!level_o[1]) level_dropped = 1'b1;
                checks++;
                if ({pulse_o, stretch_o, sticky_o, level_o} !== {exp_pulse, exp_stretch, exp_sticky, exp_level}) begin
                    errors++;
                    $display("FAIL glitch_model len=%0d cyc=%0d got p=%h s=%h k=%h l=%h exp p=%h s=%h k=%h l=%h",
                             lowlen, c, pulse_o, stretch_o, sticky_o, level_o,
                             exp_pulse, exp_stretch, exp_sticky, exp_level);
                end
            end
            checks++;
            if (pcount != t || level_dropped != t[0]) begin
                errors++;
                $display("FAIL glitch_len%0d got pulses=%0d dropped=%0d exp pulses=%0d dropped=%0d",
                         lowlen, pcount, level_dropped, t, t);
            end
        end
    endtask

    task automatic test_back_to_back();
        int p1 = -1;
        int p2 = -1;
        int sfirst = -1;
        int slast = -1;
        int scount = 0;
        mode = 2'b11;
        edge_sig[2] = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c == 5) edge_sig[2] = 1'b1;
            step();
            if (pulse_o[2]) begin
                if (p1 < 0) p1 = c;
                else p2 = c;
            end
            if (stretch_o[2]) begin
                scount++;
                if (sfirst < 0) sfirst = c;
                slast = c;
            end
            checks++;
            if ({pulse_o, stretch_o, sticky_o, level_o} !== {exp_pulse, exp_stretch, exp_sticky, exp_level}) begin
                errors++;
                $display("FAIL b2b_model cyc=%0d got p=%h s=%h k=%h l=%h exp p=%h s=%h k=%h l=%h", c,
                         pulse_o, stretch_o, sticky_o, level_o, exp_pulse, exp_stretch, exp_sticky, exp_level);
            end
        end
        checks++;
        if (p1 != 6 || p2 != 11 || scount != 13 || slast - sfirst != 12) begin
            errors++;
            $display("FAIL b2b_timing got p1=%0d p2=%0d stretch=%0d span=%0d exp p1=6 p2=11 stretch=13 span=12",
                     p1, p2, scount, slast - sfirst);
        end
    endtask

    task automatic test_mode();
        int pcount = 0;
        mode = 2'b01;
        edge_sig[3] = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c == 12) edge_sig[3] = 1'b1;
            step();
            if (pulse_o[3]) pcount++;
            checks++;
            if ({pulse_o, stretch_o, sticky_o, level_o} !== {exp_pulse, exp_stretch, exp_sticky, exp_level}) begin
                errors++;
                $display("FAIL mode01_model cyc=%0d got p=%h s=%h k=%h l=%h exp p=%h s=%h k=%h l=%h", c,
                         pulse_o, stretch_o, sticky_o, level_o, exp_pulse, exp_stretch, exp_sticky, exp_level);
            end
        end
        checks++;
        if (pcount != 1) begin
            errors++;
            $display("FAIL mode01_rise_only got pulses=%0d exp 1", pcount);
        end
        mode = 2'b00;
        pcount = 0;
        for (int c = 0; c < 40; c++) begin
            if (c % 10 == 0) edge_sig[3] = ~edge_sig[3];
            step();
            if (pulse_o != 4'h0) pcount++;
            checks++;
            if ({pulse_o, stretch_o, sticky_o, level_o} !== {exp_pulse, exp_stretch, exp_sticky, exp_level}) begin
                errors++;
                $display("FAIL mode00_model cyc=%0d got p=%h s=%h k=%h l=%h exp p=%h s=%h k=%h l=%h", c,
                         pulse_o, stretch_o, sticky_o, level_o, exp_pulse, exp_stretch, exp_sticky, exp_level);
            end
        end
        checks++;
        if (pcount != 0 || level_o[3] !== edge_sig[3]) begin
            errors++;
            $display("FAIL mode00_silent got pulses=%0d l3=%b exp pulses=0 l3=%b", pcount, level_o[3], edge_sig[3]);
        end
    endtask

    task automatic test_sticky_clr();
        bit found = 1'b0;
        checks++;
        if (sticky_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL sticky_pre got %b exp 1", sticky_o[0]);
        end
        mode = 2'b11;
        edge_sig[0] = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (m_ev[0]) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL sticky_event_timeout got none exp event within 20 cycles");
        end
        clr = 4'h1;
        step();
        checks++;
        if (sticky_o[0] !== 1'b1 || pulse_o[0] !== 1'b1 || exp_sticky[0] !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set_wins got k0=%b p0=%b exp k0=1 p0=1", sticky_o[0], pulse_o[0]);
        end
        step();
        checks++;
        if (sticky_o[0] !== 1'b0 || sticky_o !== exp_sticky) begin
            errors++;
            $display("FAIL sticky_clear got k=%h exp k=%h", sticky_o, exp_sticky & 4'hE);
        end
        clr = 4'h0;
        // reset in the middle of a stretched pulse
        edge_sig[0] = 1'b0;
        repeat (9) step();
        checks++;
        if (stretch_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL midstretch_pre got s0=%b exp 1", stretch_o[0]);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pulse_o, stretch_o, sticky_o, level_o} !== {4'h0, 4'h0, 4'h0, 4'hF}) begin
            errors++;
            $display("FAIL async_reset got p=%h s=%h k=%h l=%h exp p=0 s=0 k=0 l=f",
                     pulse_o, stretch_o, sticky_o, level_o);
        end
        model_reset();
        edge_sig = 4'hF;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            if ({pulse_o, stretch_o, sticky_o, level_o} !== {4'h0, 4'h0, 4'h0, 4'hF}) begin
                errors++;
                $display("FAIL release_quiet cyc=%0d got p=%h s=%h k=%h l=%h exp p=0 s=0 k=0 l=f",
                         c, pulse_o, stretch_o, sticky_o, level_o);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int ch = 0; ch < CH; ch++) begin
                if ($urandom_range(0, 5) == 0) edge_sig[ch] = ~edge_sig[ch];
                clr[ch] = ($urandom_range(0, 9) == 0);
            end
            if (c % 40 == 0) mode = 2'($urandom_range(0, 3));
            if (c == 300) begin
                #2;
                reset_n = 1'b0;
                #1;
                checks++;
                if ({pulse_o, stretch_o, sticky_o, level_o} !== {4'h0, 4'h0, 4'h0, 4'hF}) begin
                    errors++;
                    $display("FAIL rand_reset got p=%h s=%h k=%h l=%h exp p=0 s=0 k=0 l=f",
                             pulse_o, stretch_o, sticky_o, level_o);
                end
                model_reset();
                repeat (2) @(posedge clk);
                #1;
                reset_n = 1'b1;
            end
            step();
            checks++;
            if ({pulse_o, stretch_o, sticky_o, level_o} !== {exp_pulse, exp_stretch, exp_sticky, exp_level}) begin
                errors++;
                $display("FAIL rand_model cyc=%0d got p=%h s=%h k=%h l=%h exp p=%h s=%h k=%h l=%h", c,
                         pulse_o, stretch_o, sticky_o, level_o, exp_pulse, exp_stretch, exp_sticky, exp_level);
            end
        end
        clr = '0;
    endtask

    initial begin
        test_reset();
        test_falling();
        test_glitch();
        test_back_to_back();
        test_mode();
        test_sticky_clr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
